tdc_result_stats: RTL and testbench

Windowed statistics accumulator that sits directly downstream of the single-channel TDC core. It consumes each accepted measurement (interval plus error strobe) and accumulates min, max, sum and error count over a fixed window of 2^WINDOW_LOG2 measurements. It then emits one statistics record per window over a valid/ready handshake. Its purpose is to reduce ILA/host bandwidth and provide a jitter (spread) figure without calibration.

---
 rtl/tdc_result_stats.sv | 194 +++++++++++++++++++
 tb/tb_tdc_result_stats.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/tdc_result_stats.sv
// Windowed min/max/mean/spread/error statistics over 2^WINDOW_LOG2 TDC measurements,
// emitting one record per window on a valid/ready output register.
module tdc_result_stats #(
  parameter int DATA_W      = 32,
  parameter int WINDOW_LOG2 = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   meas_valid,
  input  logic [DATA_W-1:0]      meas_interval,
  input  logic                   meas_error,
  input  logic                   clear,
  output logic                   stats_valid,
  input  logic                   stats_ready,
  output logic [DATA_W-1:0]      stats_min,
  output logic [DATA_W-1:0]      stats_max,
  output logic [DATA_W-1:0]      stats_mean,
  output logic [DATA_W-1:0]      stats_spread,
  output logic [15:0]            stats_err_count,
  output logic [WINDOW_LOG2:0]   window_fill,
  output logic                   overrun,
  output logic [7:0]             drop_count
);

  localparam int SUM_W = DATA_W + WINDOW_LOG2;
  localparam logic [WINDOW_LOG2:0] LAST_FILL = {1'b0, {WINDOW_LOG2{1'b1}}};
  localparam logic [WINDOW_LOG2:0] FILL_ONE  = {{WINDOW_LOG2{1'b0}}, 1'b1};

  typedef enum logic {
    EMPTY,
    ACCUM
  } acc_state_t;

  acc_state_t            state_reg, state_next;
  logic [WINDOW_LOG2:0]  fill_reg, fill_next;
  logic [DATA_W-1:0]     run_min_reg, run_min_next;
  logic [DATA_W-1:0]     run_max_reg, run_max_next;
  logic [SUM_W-1:0]      run_sum_reg, run_sum_next;
  logic [15:0]           run_err_reg, run_err_next;

  // Running values with this cycle's sample/error folded in
  logic [DATA_W-1:0]     sample_min;
  logic [DATA_W-1:0]     sample_max;
  logic [SUM_W-1:0]      sample_sum;
  logic [15:0]           sample_err;

  logic                  complete;
  logic                  load;
  logic                  drop;

  logic                  stats_valid_reg;
  logic [DATA_W-1:0]     stats_min_reg;
  logic [DATA_W-1:0]     stats_max_reg;
  logic [DATA_W-1:0]     stats_mean_reg;
  logic [DATA_W-1:0]     stats_spread_reg;
  logic [15:0]           stats_err_reg;
  logic                  overrun_reg;
  logic [7:0]            drop_count_reg;

  always_comb begin
    sample_min = run_min_reg;
    sample_max = run_max_reg;
    sample_sum = run_sum_reg;
    sample_err = run_err_reg;
    if (meas_valid) begin
      if (meas_interval < run_min_reg) begin
        sample_min = meas_interval;
      end
      if (meas_interval > run_max_reg) begin
        sample_max = meas_interval;
      end
      sample_sum = run_sum_reg + {{WINDOW_LOG2{1'b0}}, meas_interval};
    end
    if (meas_error && (run_err_reg != 16'hFFFF)) begin
      sample_err = run_err_reg + 16'd1;
    end
  end

  always_comb begin
    state_next   = state_reg;
    fill_next    = fill_reg;
    run_min_next = run_min_reg;
    run_max_next = run_max_reg;
    run_sum_next = run_sum_reg;
    run_err_next = run_err_reg;
    complete     = 1'b0;

    if (clear) begin
      state_next   = EMPTY;
      fill_next    = '0;
      run_min_next = '1;
      run_max_next = '0;
      run_sum_next = '0;
      run_err_next = '0;
    end else begin
      case (state_reg)
        EMPTY: begin
          run_err_next = sample_err;
          if (meas_valid) begin
            state_next   = ACCUM;
            fill_next    = FILL_ONE;
            run_min_next = sample_min;
            run_max_next = sample_max;
            run_sum_next = sample_sum;
          end
        end
        ACCUM: begin
          run_err_next = sample_err;
          if (meas_valid) begin
            if (fill_reg == LAST_FILL) begin
              // Final sample: record is built from sample_* and accumulators restart
              complete     = 1'b1;
              state_next   = EMPTY;
              fill_next    = '0;
              run_min_next = '1;
              run_max_next = '0;
              run_sum_next = '0;
              run_err_next = '0;
            end else begin
              fill_next    = fill_reg + FILL_ONE;
              run_min_next = sample_min;
              run_max_next = sample_max;
              run_sum_next = sample_sum;
            end
          end
        end
        default: begin
          state_next = EMPTY;
          fill_next  = '0;
        end
      endcase
    end
  end

  assign load = complete && (!stats_valid_reg || stats_ready);
  assign drop = complete && !load;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= EMPTY;
      fill_reg    <= '0;
      run_min_reg <= '1;
      run_max_reg <= '0;
      run_sum_reg <= '0;
      run_err_reg <= '0;
    end else begin
      state_reg   <= state_next;
      fill_reg    <= fill_next;
      run_min_reg <= run_min_next;
      run_max_reg <= run_max_next;
      run_sum_reg <= run_sum_next;
      run_err_reg <= run_err_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stats_valid_reg  <= 1'b0;
      stats_min_reg    <= '0;
      stats_max_reg    <= '0;
      stats_mean_reg   <= '0;
      stats_spread_reg <= '0;
      stats_err_reg    <= '0;
      overrun_reg      <= 1'b0;
      drop_count_reg   <= '0;
    end else begin
      stats_valid_reg <= load || (stats_valid_reg && !stats_ready);
      if (load) begin
        stats_min_reg    <= sample_min;
        stats_max_reg    <= sample_max;
        stats_mean_reg   <= sample_sum[SUM_W-1:WINDOW_LOG2];
        stats_spread_reg <= sample_max - sample_min;
        stats_err_reg    <= sample_err;
      end
      if (drop) begin
        overrun_reg <= 1'b1;
        if (drop_count_reg != 8'hFF) begin
          drop_count_reg <= drop_count_reg + 8'd1;
        end
      end
    end
  end

  assign stats_valid     = stats_valid_reg;
  assign stats_min       = stats_min_reg;
  assign stats_max       = stats_max_reg;
  assign stats_mean      = stats_mean_reg;
  assign stats_spread    = stats_spread_reg;
  assign stats_err_count = stats_err_reg;
  assign window_fill     = fill_reg;
  assign overrun         = overrun_reg;
  assign drop_count      = drop_count_reg;

endmodule

// File: tb/tb_tdc_result_stats.sv
// Directed, table-driven check of tdc_result_stats with a 4-sample window.
module tb_tdc_result_stats;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        meas_valid;
  logic [31:0] meas_interval;
  logic        meas_error;
  logic        clear;
  logic        stats_valid;
  logic        stats_ready;
  logic [31:0] stats_min;
  logic [31:0] stats_max;
  logic [31:0] stats_mean;
  logic [31:0] stats_spread;
  logic [15:0] stats_err_count;
  logic [2:0]  window_fill;
  logic        overrun;
  logic [7:0]  drop_count;

  int checks = 0;
  int errors = 0;

  tdc_result_stats #(.DATA_W(32), .WINDOW_LOG2(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .meas_valid     (meas_valid),
    .meas_interval  (meas_interval),
    .meas_error     (meas_error),
    .clear          (clear),
    .stats_valid    (stats_valid),
    .stats_ready    (stats_ready),
    .stats_min      (stats_min),
    .stats_max      (stats_max),
    .stats_mean     (stats_mean),
    .stats_spread   (stats_spread),
    .stats_err_count(stats_err_count),
    .window_fill    (window_fill),
    .overrun        (overrun),
    .drop_count     (drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [31:0] x;
    logic        e;
    logic        c;
    logic        rdy;
    logic [2:0]  fill;
    logic        sv;
    logic [31:0] mn;
    logic [31:0] mx;
    logic [31:0] mean;
    logic [31:0] spr;
    logic [15:0] err;
    logic        ovr;
    logic [7:0]  drop;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic v, input logic [31:0] x, input logic e, input logic c,
                     input logic rdy, input logic [2:0] fill, input logic sv,
                     input logic [31:0] mn, input logic [31:0] mx, input logic [31:0] mean,
                     input logic [31:0] spr, input logic [15:0] err, input logic ovr,
                     input logic [7:0] drop);
    vec_t t;
    t.v = v; t.x = x; t.e = e; t.c = c; t.rdy = rdy; t.fill = fill; t.sv = sv;
    t.mn = mn; t.mx = mx; t.mean = mean; t.spr = spr; t.err = err; t.ovr = ovr; t.drop = drop;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input logic [31:0] x);
    meas_valid    = 1'b1;
    meas_interval = x;
    step();
    meas_valid    = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; meas_valid = 1'b0; meas_interval = '0; meas_error = 1'b0;
    clear = 1'b0; stats_ready = 1'b0;

    // window 100,300,200,400 then idle drain
    add(1, 100, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 300, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 200, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 400, 0, 0, 1, 0, 1, 100, 400, 250, 300, 0, 0, 0);
    add(0, 0,   0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // error in EMPTY, error coincident with a sample
    add(0, 0,   1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 100, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 300, 1, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 200, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 400, 0, 0, 1, 0, 1, 100, 400, 250, 300, 2, 0, 0);
    // mean truncation, back-to-back with the drain
    add(1, 7,   0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 7,   0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 7,   0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 8,   0, 0, 1, 0, 1, 7, 8, 7, 1, 0, 0, 0);
    add(0, 0,   0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // back-pressure: second window dropped, first held
    add(1, 1,   0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 2,   0, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 3,   0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 4,   0, 0, 0, 0, 1, 1, 4, 2, 3, 0, 0, 0);
    add(1, 5,   0, 0, 0, 1, 1, 1, 4, 2, 3, 0, 0, 0);
    add(1, 6,   0, 0, 0, 2, 1, 1, 4, 2, 3, 0, 0, 0);
    add(1, 7,   0, 0, 0, 3, 1, 1, 4, 2, 3, 0, 0, 0);
    add(1, 8,   0, 0, 0, 0, 1, 1, 4, 2, 3, 0, 1, 1);
    add(0, 0,   0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    // clear wins over a coincident sample and error
    add(1, 1000, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1);
    add(1, 1000, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 1, 1);
    add(1, 1000, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 1, 1);
    add(1, 1000, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    add(1, 10,  0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1);
    add(1, 20,  0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 1, 1);
    add(1, 30,  0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 1, 1);
    add(1, 40,  0, 0, 1, 0, 1, 10, 40, 25, 30, 0, 1, 1);
    add(0, 0,   0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    // extremes
    add(1, 32'h0,        0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1);
    add(1, 32'hFFFFFFFF, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 1, 1);
    add(1, 32'h0,        0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 1, 1);
    add(1, 32'hFFFFFFFF, 0, 0, 1, 0, 1, 32'h0, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'hFFFFFFFF, 0, 1, 1);
    add(0, 0,   0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    // record drained in the same cycle a new one completes: no drop
    add(1, 1,   0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1);
    add(1, 1,   0, 0, 0, 2, 0, 0, 0, 0, 0, 0, 1, 1);
    add(1, 1,   0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 1, 1);
    add(1, 1,   0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 1, 1);
    add(1, 2,   0, 0, 0, 1, 1, 1, 1, 1, 0, 0, 1, 1);
    add(1, 2,   0, 0, 0, 2, 1, 1, 1, 1, 0, 0, 1, 1);
    add(1, 2,   0, 0, 0, 3, 1, 1, 1, 1, 0, 0, 1, 1);
    add(1, 2,   0, 0, 1, 0, 1, 2, 2, 2, 0, 0, 1, 1);
    add(0, 0,   0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1);

    repeat (3) step();
    chk("reset_valid",  {31'd0, stats_valid}, 32'd0);
    chk("reset_min",    stats_min, 32'd0);
    chk("reset_max",    stats_max, 32'd0);
    chk("reset_mean",   stats_mean, 32'd0);
    chk("reset_spread", stats_spread, 32'd0);
    chk("reset_err",    {16'd0, stats_err_count}, 32'd0);
    chk("reset_fill",   {29'd0, window_fill}, 32'd0);
    chk("reset_ovr",    {31'd0, overrun}, 32'd0);
    chk("reset_drop",   {24'd0, drop_count}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      meas_valid    = vecs[i].v;
      meas_interval = vecs[i].x;
      meas_error    = vecs[i].e;
      clear         = vecs[i].c;
      stats_ready   = vecs[i].rdy;
      step();
      $display("vec %0d: v=%0b x=%0h e=%0b c=%0b rdy=%0b -> fill=%0d sv=%0b min=%0h max=%0h mean=%0h spr=%0h err=%0d ovr=%0b drop=%0d",
               i, vecs[i].v, vecs[i].x, vecs[i].e, vecs[i].c, vecs[i].rdy, window_fill, stats_valid,
               stats_min, stats_max, stats_mean, stats_spread, stats_err_count, overrun, drop_count);
      chk($sformatf("vec%0d_fill", i),  {29'd0, window_fill}, {29'd0, vecs[i].fill});
      chk($sformatf("vec%0d_valid", i), {31'd0, stats_valid}, {31'd0, vecs[i].sv});
      chk($sformatf("vec%0d_ovr", i),   {31'd0, overrun}, {31'd0, vecs[i].ovr});
      chk($sformatf("vec%0d_drop", i),  {24'd0, drop_count}, {24'd0, vecs[i].drop});
      if (vecs[i].sv) begin
        chk($sformatf("vec%0d_min", i),    stats_min, vecs[i].mn);
        chk($sformatf("vec%0d_max", i),    stats_max, vecs[i].mx);
        chk($sformatf("vec%0d_mean", i),   stats_mean, vecs[i].mean);
        chk($sformatf("vec%0d_spread", i), stats_spread, vecs[i].spr);
        chk($sformatf("vec%0d_err", i),    {16'd0, stats_err_count}, {16'd0, vecs[i].err});
      end
    end
    meas_valid = 1'b0; meas_error = 1'b0; clear = 1'b0;

    // 301 windows under back-pressure: one loaded, 300 dropped
    stats_ready = 1'b0;
    for (int w = 0; w < 301; w++) begin
      for (int s = 0; s < 4; s++) sample(32'd9);
    end
    $display("saturation: sv=%0b min=%0d drop=%0d ovr=%0b", stats_valid, stats_min, drop_count, overrun);
    chk("sat_drop",  {24'd0, drop_count}, 32'd255);
    chk("sat_ovr",   {31'd0, overrun}, 32'd1);
    chk("sat_valid", {31'd0, stats_valid}, 32'd1);
    chk("sat_min",   stats_min, 32'd9);

    // reset with two samples accumulated and a record pending
    sample(32'd1);
    sample(32'd1);
    chk("pre_rst_fill", {29'd0, window_fill}, 32'd2);
    rst_n = 1'b0; meas_valid = 1'b1; meas_interval = 32'd1;
    step();
    meas_valid = 1'b0;
    $display("mid reset: sv=%0b fill=%0d ovr=%0b drop=%0d", stats_valid, window_fill, overrun, drop_count);
    chk("rst_valid",  {31'd0, stats_valid}, 32'd0);
    chk("rst_min",    stats_min, 32'd0);
    chk("rst_mean",   stats_mean, 32'd0);
    chk("rst_fill",   {29'd0, window_fill}, 32'd0);
    chk("rst_ovr",    {31'd0, overrun}, 32'd0);
    chk("rst_drop",   {24'd0, drop_count}, 32'd0);
    rst_n = 1'b1;
    step();

    stats_ready = 1'b1;
    sample(32'd5);
    sample(32'd6);
    sample(32'd7);
    sample(32'd8);
    $display("post reset window: sv=%0b min=%0d max=%0d mean=%0d spr=%0d", stats_valid, stats_min, stats_max, stats_mean, stats_spread);
    chk("post_valid",  {31'd0, stats_valid}, 32'd1);
    chk("post_min",    stats_min, 32'd5);
    chk("post_max",    stats_max, 32'd8);
    chk("post_mean",   stats_mean, 32'd6);
    chk("post_spread", stats_spread, 32'd3);
    chk("post_err",    {16'd0, stats_err_count}, 32'd0);
    chk("post_fill",   {29'd0, window_fill}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
